// File: rtl/microcode_pkg.sv
// Shared constants for the microcode loader: FSM encoding, frame sync byte,
// abort cause codes and the running-checksum helper.
package microcode_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_HDR   = 4'd1;
  localparam logic [3:0] ST_DATA  = 4'd2;
  localparam logic [3:0] ST_WRITE = 4'd3;
  localparam logic [3:0] ST_READ  = 4'd4;
  localparam logic [3:0] ST_CHECK = 4'd5;
  localparam logic [3:0] ST_CSUM  = 4'd6;
  localparam logic [3:0] ST_DONE  = 4'd7;
  localparam logic [3:0] ST_ERR   = 4'd8;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_WORD     = 2'b00;
  localparam logic [1:0] ERR_RANGE    = 2'b01;
  localparam logic [1:0] ERR_READBACK = 2'b10;
  localparam logic [1:0] ERR_CSUM     = 2'b11;

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/microcode_loader.sv
// Byte-stream microcode loader: parses framed words, writes each to the external
// RAM, reads it back for verification and checks the frame checksum.
module microcode_loader
  import microcode_pkg::*;
#(
  parameter int RAM_WIDTH = 22,
  parameter int ADDR_SIZE = 11,
  parameter int RAM_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 ram_wr_enb,
  output logic                 ram_rd_enb,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0] ram_wdata,
  input  logic [RAM_WIDTH-1:0] ram_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code
);

  // Bits of the first word byte that fall above RAM_WIDTH must be zero.
  localparam logic [7:0]  HI_MASK  = 8'(8'hFF << (RAM_WIDTH - 16));
  localparam logic [16:0] DEPTH_17 = 17'(RAM_DEPTH);

  logic [3:0]           r_state;
  logic [1:0]           r_hdr_idx;
  logic [1:0]           r_byte_idx;
  logic [7:0]           r_addr_hi;
  logic [7:0]           r_addr_lo;
  logic [7:0]           r_cnt_hi;
  logic [RAM_WIDTH-1:0] r_word;
  logic [ADDR_SIZE-1:0] r_cur;
  logic [15:0]          r_remaining;
  logic [7:0]           r_csum;
  logic                 r_in_ready;
  logic                 r_ram_wr_enb;
  logic                 r_ram_rd_enb;
  logic [ADDR_SIZE-1:0] r_ram_addr;
  logic [RAM_WIDTH-1:0] r_ram_wdata;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [1:0]           r_err_code;

  logic [3:0]           w_state_nxt;
  logic [1:0]           w_err_code_nxt;
  logic                 w_accept;
  logic [RAM_WIDTH-1:0] w_word_nxt;
  logic [ADDR_SIZE-1:0] w_start;
  logic [15:0]          w_count;
  logic [16:0]          w_start_17;
  logic                 w_range_bad;

  assign w_accept   = in_valid & r_in_ready;
  assign w_word_nxt = RAM_WIDTH'({r_word, in_data});
  assign w_start    = ADDR_SIZE'({r_addr_hi, r_addr_lo});
  assign w_count    = {r_cnt_hi, in_data};
  assign w_start_17 = 17'(w_start);
  assign w_range_bad = (w_start_17 >= DEPTH_17) || ((w_start_17 + {1'b0, w_count}) > DEPTH_17);

  // Next-state and abort-cause selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_err_code_nxt = r_err_code;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (in_data == SYNC_BYTE)) w_state_nxt = ST_HDR;
        else                                    w_state_nxt = ST_IDLE;
      end
      ST_HDR: begin
        if (w_accept && (r_hdr_idx == 2'd3)) begin
          if (w_range_bad) begin
            w_state_nxt    = ST_ERR;
            w_err_code_nxt = ERR_RANGE;
          end else if (w_count == 16'd0) begin
            w_state_nxt = ST_CSUM;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_DATA: begin
        if (!w_accept) begin
          w_state_nxt = ST_DATA;
        end else if ((r_byte_idx == 2'd0) && ((in_data & HI_MASK) != 8'd0)) begin
          w_state_nxt    = ST_ERR;
          w_err_code_nxt = ERR_WORD;
        end else if (r_byte_idx == 2'd2) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_WRITE: w_state_nxt = ST_READ;
      ST_READ:  w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (ram_rdata != r_word) begin
          w_state_nxt    = ST_ERR;
          w_err_code_nxt = ERR_READBACK;
        end else if (r_remaining == 16'd1) begin
          w_state_nxt = ST_CSUM;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (!w_accept) begin
          w_state_nxt = ST_CSUM;
        end else if (in_data == r_csum) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt    = ST_ERR;
          w_err_code_nxt = ERR_CSUM;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, registered outputs (decoded from next state) and frame datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hdr_idx    <= 2'd0;
      r_byte_idx   <= 2'd0;
      r_addr_hi    <= 8'd0;
      r_addr_lo    <= 8'd0;
      r_cnt_hi     <= 8'd0;
      r_word       <= '0;
      r_cur        <= '0;
      r_remaining  <= 16'd0;
      r_csum       <= 8'd0;
      r_in_ready   <= 1'b0;
      r_ram_wr_enb <= 1'b0;
      r_ram_rd_enb <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_WORD;
    end else begin
      r_state      <= w_state_nxt;
      r_in_ready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HDR) ||
                      (w_state_nxt == ST_DATA) || (w_state_nxt == ST_CSUM);
      r_ram_wr_enb <= (w_state_nxt == ST_WRITE);
      r_ram_rd_enb <= (w_state_nxt == ST_READ);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_done       <= (w_state_nxt == ST_DONE);
      r_err        <= (w_state_nxt == ST_ERR);
      if (w_state_nxt == ST_ERR) r_err_code <= w_err_code_nxt;
      if (w_state_nxt == ST_WRITE) begin
        r_ram_addr  <= r_cur;
        r_ram_wdata <= w_word_nxt;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept && (in_data == SYNC_BYTE)) begin
            r_csum     <= 8'd0;
            r_hdr_idx  <= 2'd0;
            r_byte_idx <= 2'd0;
          end
        end
        ST_HDR: begin
          if (w_accept) begin
            r_csum    <= csum_add(r_csum, in_data);
            r_hdr_idx <= r_hdr_idx + 2'd1;
            case (r_hdr_idx)
              2'd0:    r_addr_hi <= in_data;
              2'd1:    r_addr_lo <= in_data;
              2'd2:    r_cnt_hi  <= in_data;
              default: begin
                r_cur       <= w_start;
                r_remaining <= w_count;
              end
            endcase
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_csum     <= csum_add(r_csum, in_data);
            r_word     <= w_word_nxt;
            r_byte_idx <= (r_byte_idx == 2'd2) ? 2'd0 : (r_byte_idx + 2'd1);
          end
        end
        ST_CHECK: begin
          if (ram_rdata == r_word) begin
            r_cur       <= r_cur + ADDR_SIZE'(1);
            r_remaining <= r_remaining - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign ram_wr_enb = r_ram_wr_enb;
  assign ram_rd_enb = r_ram_rd_enb;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_microcode_loader.sv
// Table-driven bench for microcode_loader with a RAM model and an event scoreboard.
module tb_microcode_loader;

  localparam int RW = 22;
  localparam int AS = 11;
  localparam int RD = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          ram_wr_enb;
  logic          ram_rd_enb;
  logic [AS-1:0] ram_addr;
  logic [RW-1:0] ram_wdata;
  logic [RW-1:0] ram_rdata = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  microcode_loader #(.RAM_WIDTH(RW), .ADDR_SIZE(AS), .RAM_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_wr_enb(ram_wr_enb), .ram_rd_enb(ram_rd_enb),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // RAM model; bit 0 of the word at corrupt_addr is flipped on readback.
  logic [RW-1:0] mem [0:(1<<AS)-1];
  int corrupt_addr = -1;
  always @(posedge clk) begin
    if (ram_wr_enb) mem[ram_addr] <= ram_wdata;
    if (ram_rd_enb) ram_rdata <= mem[ram_addr] ^ ((int'(ram_addr) == corrupt_addr) ? 22'd1 : 22'd0);
  end

  typedef struct {int kind; int addr; int data; int code;} ev_t;  // kind 0 write, 1 done, 2 err
  ev_t sb[$];
  ev_t e_m;
  int n_cmp = 0;
  int n_bad = 0;
  int last_wr_addr = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int a);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event (info 0x%0h), expected none of this kind", name, a);
  endtask

  // Scoreboard monitor: every write, done and err must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_wr_enb || ram_rd_enb) chk("wr_rd_exclusive", {31'b0, ram_wr_enb & ram_rd_enb}, 32'd0);
      if (ram_wr_enb) begin
        if (sb.size() == 0 || sb[0].kind != 0) unexpected("unexpected_write", int'(ram_addr));
        else begin
          e_m = sb.pop_front();
          chk("wr_addr", 32'(ram_addr), e_m.addr);
          chk("wr_data", 32'(ram_wdata), e_m.data);
        end
        last_wr_addr = int'(ram_addr);
      end
      if (ram_rd_enb) chk("rd_addr", 32'(ram_addr), last_wr_addr);
      if (done) begin
        if (sb.size() == 0 || sb[0].kind != 1) unexpected("unexpected_done", 1);
        else e_m = sb.pop_front();
      end
      if (err) begin
        if (sb.size() == 0 || sb[0].kind != 2) unexpected("unexpected_err", int'(err_code));
        else begin
          e_m = sb.pop_front();
          chk("err_code", 32'(err_code), e_m.code);
        end
      end
    end
  end

  task automatic send_bytes(input logic [7:0] b[$], input int n);
    int i = 0;
    int guard = 0;
    logic rdy;
    while (i < n && guard < 5000) begin
      @(negedge clk);
      rdy = in_ready;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
      end else begin
        in_valid = 1'b1;
        in_data  = b[i];
      end
      @(posedge clk);
      if (in_valid && rdy) i++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (i < n) chk("send_timeout", i, n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (k < 300 && !(sb.size() == 0 && busy === 1'b0)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL completion_timeout: got %0d events pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  typedef struct {
    int addr; int cnt; int base; int step; int bad_idx; int corrupt;
    int csum_delta; int exp_err; int exp_code;
  } case_t;
  case_t tbl[10];

  task automatic run_case(input case_t c);
    logic [7:0] fr[$];
    logic [7:0] cs = 8'd0;
    logic [7:0] hb[4];
    int a0 = c.addr & 32'h7FF;
    int stop;
    int w;
    ev_t ev;
    fr.push_back(8'h3C);
    fr.push_back(8'h00);
    fr.push_back(8'hA5);
    hb[0] = 8'(c.addr >> 8); hb[1] = 8'(c.addr); hb[2] = 8'(c.cnt >> 8); hb[3] = 8'(c.cnt);
    for (int j = 0; j < 4; j++) begin
      fr.push_back(hb[j]);
      cs = cs + hb[j];
    end
    for (int i = 0; i < c.cnt; i++) begin
      w = (c.base + i * c.step) & 32'h3FFFFF;
      hb[0] = (i == c.bad_idx) ? 8'h40 : 8'(w >> 16);
      hb[1] = 8'(w >> 8);
      hb[2] = 8'(w);
      for (int j = 0; j < 3; j++) begin
        fr.push_back(hb[j]);
        cs = cs + hb[j];
      end
    end
    fr.push_back(cs + 8'(c.csum_delta));
    if (c.exp_err != 0 && c.exp_code == 1)      stop = 7;
    else if (c.bad_idx >= 0)                    stop = 7 + 3 * c.bad_idx + 1;
    else if (c.corrupt >= 0)                    stop = 7 + 3 * (c.corrupt - a0 + 1);
    else                                        stop = fr.size();
    if (!(c.exp_err != 0 && c.exp_code == 1)) begin
      for (int i = 0; i < c.cnt; i++) begin
        if (i == c.bad_idx) break;
        ev.kind = 0; ev.addr = a0 + i; ev.data = (c.base + i * c.step) & 32'h3FFFFF; ev.code = 0;
        sb.push_back(ev);
        if (a0 + i == c.corrupt) break;
      end
    end
    ev.kind = (c.exp_err != 0) ? 2 : 1; ev.addr = 0; ev.data = 0; ev.code = c.exp_code;
    sb.push_back(ev);
    corrupt_addr = c.corrupt;
    send_bytes(fr, stop);
    wait_idle();
    if (c.exp_err != 0) begin
      repeat (3) @(negedge clk);
      chk("err_code_hold", 32'(err_code), c.exp_code);
    end
    corrupt_addr = -1;
  endtask

  initial begin
    logic [7:0] fr[$];
    ev_t ev;
    //          addr     cnt base       step      bad corrupt dcs err code
    tbl[0] = '{16'h0000, 2, 32'h008000, 32'h008000, -1, -1,   0, 0, 0};
    tbl[1] = '{1020,     5, 32'h001111, 32'h000001, -1, -1,   0, 1, 1};
    tbl[2] = '{5,        3, 32'h012345, 32'h000111,  1, -1,   0, 1, 0};
    tbl[3] = '{10,       4, 32'h0ABCDE, 32'h001001, -1, 12,   0, 1, 2};
    tbl[4] = '{100,      3, 32'h200001, 32'h010101, -1, -1,   1, 1, 3};
    tbl[5] = '{1019,     5, 32'h155555, 32'h000007, -1, -1,   0, 0, 0};
    tbl[6] = '{1024,     0, 32'h000000, 32'h000000, -1, -1,   0, 1, 1};
    tbl[7] = '{16'h0300, 0, 32'h000000, 32'h000000, -1, -1,   0, 0, 0};
    tbl[8] = '{16'hF805, 1, 32'h3FFFFF, 32'h000000, -1, -1,   0, 0, 0};
    tbl[9] = '{16'h00A5, 1, 32'h25A5A5, 32'h000000, -1, -1,   0, 0, 0};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_pulses", {29'b0, done, err, ram_wr_enb | ram_rd_enb}, 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", {31'b0, in_ready}, 32'd1);

    for (int t = 0; t < 10; t++) run_case(tbl[t]);

    // Reset while collecting word bytes, then a count-0 frame.
    fr = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h03, 8'h01, 8'h02};
    send_bytes(fr, 7);
    chk("busy_mid_frame", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst_err_code", 32'(err_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ev.kind = 1; ev.addr = 0; ev.data = 0; ev.code = 0;
    sb.push_back(ev);
    fr = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h00, 8'h40};
    send_bytes(fr, 6);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/microcode_loader.md
MICROCODE_LOADER -- requirements
Module: microcode_loader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 22, microinstruction word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 11, RAM address width.
REQ-003 SHALL have parameter RAM_DEPTH, default 1024, number of valid words.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  byte-stream byte present.
REQ-007 SHALL have port in_data  input  8  byte-stream data.
REQ-008 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port ram_wr_enb  output  1  microcode RAM write enable.
REQ-010 SHALL have port ram_rd_enb  output  1  microcode RAM read enable.
REQ-011 SHALL have port ram_addr  output  ADDR_SIZE  microcode RAM address.
REQ-012 SHALL have port ram_wdata  output  RAM_WIDTH  word to RAM data_in.
REQ-013 SHALL have port ram_rdata  input  RAM_WIDTH  RAM data_out; valid one cycle after ram_rd_enb.
REQ-014 SHALL have port busy  output  1  frame in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse, frame loaded and verified.
REQ-016 SHALL have port err  output  1  one-cycle pulse, frame aborted.
REQ-017 SHALL have port err_code  output  2  cause, held until next err: 00 bad word byte, 01 range, 10 readback mismatch, 11 checksum.

Function
REQ-018 SHALL transfer a byte only when in_valid and in_ready are both 1 at posedge clk.
REQ-019 SHALL parse frame: 0xA5 sync, addr_hi, addr_lo, cnt_hi, cnt_lo, cnt words of 3 bytes MSB-first, one checksum byte.
REQ-020 SHALL, in IDLE, discard every byte except 0xA5; 0xA5 moves to HDR and sets busy.
REQ-021 SHALL form start address {addr_hi,addr_lo}[ADDR_SIZE-1:0] and count {cnt_hi,cnt_lo}.
REQ-022 SHALL abort with code 01 after cnt_lo if start >= RAM_DEPTH or start+count > RAM_DEPTH (no wrap-around permitted).
REQ-023 SHALL go directly to CSUM when count = 0.
REQ-024 SHALL abort with code 00 if first byte of a word has bits 7:6 nonzero (unused bits of 22-bit word).
REQ-025 SHALL, after the third word byte, drive WRITE (ram_wr_enb=1, ram_addr=cur, ram_wdata=word) one cycle, then READ (ram_rd_enb=1, same addr) one cycle, then CHECK comparing ram_rdata to word.
REQ-026 SHALL abort with code 10 on CHECK mismatch; otherwise increment cur and return to DATA, or go to CSUM after last word.
REQ-027 SHALL hold in_ready=0 in WRITE, READ, CHECK, DONE, ERR; in_ready=1 in IDLE, HDR, DATA, CSUM.
REQ-028 SHALL compute checksum as 8-bit modulo-256 sum of all bytes after sync, excluding checksum byte; mismatch aborts with code 11.
REQ-029 SHALL never assert ram_wr_enb and ram_rd_enb in the same cycle; both 0 outside WRITE/READ.
REQ-030 SHALL pulse done for one cycle (DONE state) on checksum match, then return to IDLE, busy=0.
REQ-031 SHALL on abort pulse err one cycle (ERR state), update err_code, return to IDLE; words already written stay written.
REQ-032 SHALL treat 0xA5 inside a frame as ordinary data (no resync mid-frame).

Reset
REQ-033 SHALL on rst_n=0, immediately and asynchronously: state IDLE, in_ready=0, ram_wr_enb=0, ram_rd_enb=0, ram_addr=0, ram_wdata=0, busy=0, done=0, err=0, err_code=00, checksum=0; in_ready=1 from first clock after release.
REQ-034 SHALL, on reset mid-frame, discard the frame with no done/err pulse.

Structure
REQ-035 SHALL place state encoding, sync value 0xA5, and err_code constants in shared package microcode_pkg.
REQ-036 SHALL be a single module, no sub-modules; the microcode RAM is external.

Verification
REQ-037 SHALL test: frame addr 0, count 2, words 0x008000, 0x010000, correct checksum -> two write/read pairs at addr 0,1; done pulse; err never.
REQ-038 SHALL test: frame addr 1020, count 5 -> err, err_code 01, no ram_wr_enb.
REQ-039 SHALL test: word first byte 0x40 -> err, err_code 00, no write for that word.
REQ-040 SHALL test: RAM model corrupts bit 0 on readback of addr 12 -> err, err_code 10 in CHECK.
REQ-041 SHALL test: checksum off by one -> all words written, err, err_code 11, no done.
REQ-042 SHALL test: rst_n low during DATA, then valid frame count 0 -> no pulse from first frame, done for second; in_valid toggling randomly throughout.
